// File: rtl/mux_stage.sv
// mux_stage: N-way signed channel select feeding a 2-entry FIFO output buffer.
// Optional macro MUX_SEL_CHECK_EN drops out-of-range selects and raises sticky out_err.
module mux_stage #(
  parameter int WIDTH  = 9,
  parameter int NUM_IN = 10,
  parameter int SEL_W  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic        [NUM_IN*WIDTH-1:0] in_data,
  input  logic        [SEL_W-1:0]        in_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic signed [WIDTH-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_err
);

  logic        [1:0]       count_r;
  logic                    wr_ptr_r;
  logic                    rd_ptr_r;
  logic signed [WIDTH-1:0] mem0_r;
  logic signed [WIDTH-1:0] mem1_r;

  logic signed [WIDTH-1:0] chan_val_s;
  logic                    push_s;
  logic                    pop_s;
  logic        [1:0]       count_n_s;
  logic                    wr_ptr_n_s;
  logic                    rd_ptr_n_s;
  logic signed [WIDTH-1:0] mem0_n_s;
  logic signed [WIDTH-1:0] mem1_n_s;
  logic signed [WIDTH-1:0] head_n_s;

  // Channel selection; an out-of-range select yields zero.
  always_comb begin
    chan_val_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        chan_val_s = in_data[k*WIDTH +: WIDTH];
      end else begin
        chan_val_s = chan_val_s;
      end
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_ok_s;
  logic accept_s;
  logic err_r;

  assign sel_ok_s = ({1'b0, in_sel} < (SEL_W+1)'(NUM_IN));
  assign accept_s = in_valid & in_ready;
  // Bad selects complete the handshake but never enter the buffer.
  assign push_s   = accept_s & sel_ok_s;
  assign out_err  = err_r;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (accept_s & ~sel_ok_s);
    end
  end
`else
  assign push_s  = in_valid & in_ready;
  assign out_err = 1'b0;
`endif

  assign pop_s = out_valid & out_ready;

  // Next buffer state; outputs are then registered from it.
  always_comb begin
    mem0_n_s = mem0_r;
    mem1_n_s = mem1_r;
    if (push_s) begin
      if (wr_ptr_r) begin
        mem1_n_s = chan_val_s;
      end else begin
        mem0_n_s = chan_val_s;
      end
    end else begin
      mem0_n_s = mem0_r;
    end
    wr_ptr_n_s = wr_ptr_r ^ push_s;
    rd_ptr_n_s = rd_ptr_r ^ pop_s;
    count_n_s  = count_r + {1'b0, push_s} - {1'b0, pop_s};
    head_n_s   = rd_ptr_n_s ? mem1_n_s : mem0_n_s;
  end

  // Buffer storage, pointers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= 2'd0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      mem0_r    <= '0;
      mem1_r    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      count_r   <= count_n_s;
      wr_ptr_r  <= wr_ptr_n_s;
      rd_ptr_r  <= rd_ptr_n_s;
      mem0_r    <= mem0_n_s;
      mem1_r    <= mem1_n_s;
      in_ready  <= (count_n_s < 2'd2);
      out_valid <= (count_n_s != 2'd0);
      out_data  <= (count_n_s != 2'd0) ? head_n_s : '0;
    end
  end

endmodule

// File: tb/tb_mux_stage.sv
// Self-checking bench for mux_stage: directed scenarios on the default build
// plus a randomized 16x16 run against a queue-based reference model.
module tb_mux_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Default-parameter instance
  logic              a_rst;
  logic [89:0]       a_in_data;
  logic [3:0]        a_in_sel;
  logic              a_in_valid;
  logic              a_in_ready;
  logic signed [8:0] a_out_data;
  logic              a_out_valid;
  logic              a_out_ready;
  logic              a_out_err;

  mux_stage dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_err(a_out_err)
  );

  // Wide instance for the random run
  logic               b_rst;
  logic [255:0]       b_in_data;
  logic [3:0]         b_in_sel;
  logic               b_in_valid;
  logic               b_in_ready;
  logic signed [15:0] b_out_data;
  logic               b_out_valid;
  logic               b_out_ready;
  logic               b_out_err;

  mux_stage #(.WIDTH(16), .NUM_IN(16), .SEL_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_err(b_out_err)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int v);
    logic [8:0] v9;
    v9 = v[8:0];
    a_in_data[k*9 +: 9] = v9;
  endtask

  task automatic chk_a(input string tag, input int ov, input int od, input int ir);
    chk({tag, ".out_valid"}, {31'd0, a_out_valid}, ov);
    chk({tag, ".out_data"},  a_out_data, od);
    chk({tag, ".in_ready"},  {31'd0, a_in_ready}, ir);
  endtask

  int q[$];
  int exp_data;
  bit acc;
  bit pop;
  int sel;
  int val;

  initial begin
    a_rst = 1'b1; a_in_data = '0; a_in_sel = 4'd0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_in_data = '0; b_in_sel = 4'd0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    cyc();
    cyc();
    a_rst = 1'b0; b_rst = 1'b0;
    chk_a("reset", 0, 0, 1);
    chk("reset.out_err", {31'd0, a_out_err}, 0);

    // Single push with 1-cycle latency
    set_ch(3, -5); a_in_sel = 4'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    chk_a("lat1", 1, -5, 1);
    cyc();
    chk_a("lat1_drain", 0, 0, 1);

    // Fill, back-pressure, ordered drain
    a_out_ready = 1'b0;
    set_ch(0, 100); set_ch(9, -256); set_ch(1, 55);
    a_in_sel = 4'd0; a_in_valid = 1'b1;
    cyc();
    chk_a("fill1", 1, 100, 1);
    a_in_sel = 4'd9;
    cyc();
    chk_a("fill2", 1, 100, 0);
    a_in_sel = 4'd1;
    cyc();
    chk_a("full_hold", 1, 100, 0);
    a_out_ready = 1'b1;
    cyc();
    chk_a("pop_full", 1, -256, 1);
    cyc();
    a_in_valid = 1'b0;
    chk_a("third_in", 1, 55, 1);
    cyc();
    chk_a("drain_empty", 0, 0, 1);

    // Simultaneous push and pop at count 1
    a_out_ready = 1'b0;
    set_ch(4, 20); a_in_sel = 4'd4; a_in_valid = 1'b1;
    cyc();
    chk_a("pp_setup", 1, 20, 1);
    set_ch(1, 7); a_in_sel = 4'd1; a_out_ready = 1'b1;
    cyc();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk_a("push_pop", 1, 7, 1);
    a_out_ready = 1'b1;
    cyc();
    chk_a("pp_drain", 0, 0, 1);

    // Out-of-range select
    a_out_ready = 1'b0;
    a_in_sel = 4'd12; a_in_valid = 1'b1;
    cyc();
    a_in_sel = 4'd3;
`ifdef MUX_SEL_CHECK_EN
    chk_a("oor", 0, 0, 1);
    chk("oor.out_err", {31'd0, a_out_err}, 1);
    cyc();
    a_in_valid = 1'b0;
    chk_a("oor_next", 1, -5, 1);
    chk("oor_sticky", {31'd0, a_out_err}, 1);
    a_out_ready = 1'b1;
    cyc();
    chk_a("oor_drain", 0, 0, 1);
    cyc();
    chk("oor_sticky2", {31'd0, a_out_err}, 1);
`else
    chk_a("oor", 1, 0, 1);
    chk("oor.out_err", {31'd0, a_out_err}, 0);
    cyc();
    a_in_valid = 1'b0;
    chk_a("oor_next", 1, 0, 0);
    a_out_ready = 1'b1;
    cyc();
    chk_a("oor_drain1", 1, -5, 1);
    cyc();
    chk_a("oor_drain2", 0, 0, 1);
    chk("oor.out_err2", {31'd0, a_out_err}, 0);
`endif

    // Reset while full, then resume
    a_out_ready = 1'b0;
    a_in_sel = 4'd0; a_in_valid = 1'b1;
    cyc();
    a_in_sel = 4'd9;
    cyc();
    chk_a("pre_rst_full", 1, 100, 0);
    a_rst = 1'b1; a_in_sel = 4'd1;
    cyc();
    a_rst = 1'b0; a_in_valid = 1'b0;
    chk_a("mid_rst", 0, 0, 1);
    chk("mid_rst.out_err", {31'd0, a_out_err}, 0);
    set_ch(2, 1); a_in_sel = 4'd2; a_in_valid = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    chk_a("post_rst", 1, 1, 1);

    // Random back-to-back traffic against a queue model
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 8; k++) b_in_data[k*32 +: 32] = $urandom;
      b_in_sel    = 4'($urandom_range(15, 0));
      b_in_valid  = ($urandom_range(3, 0) != 0);
      b_out_ready = ($urandom_range(1, 0) != 0);
      sel = int'(b_in_sel);
      val = int'($signed(b_in_data[sel*16 +: 16]));
      acc = b_in_valid && (q.size() < 2);
      pop = b_out_ready && (q.size() > 0);
      cyc();
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(val);
      exp_data = (q.size() > 0) ? q[0] : 0;
      chk("rnd.out_valid", {31'd0, b_out_valid}, (q.size() > 0) ? 1 : 0);
      chk("rnd.out_data",  b_out_data, exp_data);
      chk("rnd.in_ready",  {31'd0, b_in_ready}, (q.size() < 2) ? 1 : 0);
    end
    chk("rnd.out_err", {31'd0, b_out_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
